ps2_paddle_keys: RTL



---
 rtl/ps2_paddle_keys.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ps2_paddle_keys.sv
// PS/2 keyboard receiver and make/break decoder for the paddle controls.
// Produces a held-key vector matching the onboard button layout.
module ps2_paddle_keys #(
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  KEY_LU = 8'h1D,
  parameter logic [7:0]  KEY_LD = 8'h1B,
  parameter logic [7:0]  KEY_RU = 8'h75,
  parameter logic [7:0]  KEY_RD = 8'h72
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [3:0]  keys,
  output logic [31:0] key_code,
  output logic        code_valid,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  logic          clk_s1_q, clk_s2_q, clk_s3_q;
  logic          dat_s1_q, dat_s2_q;
  logic [9:0]    sh_q, sh_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  state_t        state_q, state_d;
  logic [3:0]    keys_q, keys_d;
  logic [31:0]   code_q, code_d;
  logic          cv_q, cv_d;
  logic          fe_q, fe_d;

  logic          fall;
  logic [10:0]   frame;
  logic [7:0]    b;

  assign fall  = clk_s3_q & ~clk_s2_q;
  assign frame = {dat_s2_q, sh_q};
  assign b     = frame[8:1];

  always_comb begin
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    state_d   = state_q;
    keys_d    = keys_q;
    code_d    = code_q;
    cv_d      = 1'b0;
    fe_d      = 1'b0;
    if (fall) begin
      tmo_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = '0;
        if (!frame[0] && frame[10] && (^frame[9:1])) begin
          cv_d   = 1'b1;
          code_d = {code_q[23:0], b};
          unique case (state_q)
            S_IDLE: begin
              if (b == 8'hE0) begin
                state_d = S_EXT;
              end else if (b == 8'hF0) begin
                state_d = S_BRK;
              end else if (b == 8'hAA) begin
                keys_d = '0;
              end else begin
                if (b == KEY_LU) keys_d[3] = 1'b1;
                if (b == KEY_LD) keys_d[2] = 1'b1;
              end
            end
            S_EXT: begin
              state_d = S_IDLE;
              if (b == 8'hF0) begin
                state_d = S_EXT_BRK;
              end else begin
                if (b == KEY_RU) keys_d[1] = 1'b1;
                if (b == KEY_RD) keys_d[0] = 1'b1;
              end
            end
            S_BRK: begin
              state_d = S_IDLE;
              if (b == KEY_LU) keys_d[3] = 1'b0;
              if (b == KEY_LD) keys_d[2] = 1'b0;
            end
            S_EXT_BRK: begin
              state_d = S_IDLE;
              if (b == KEY_RU) keys_d[1] = 1'b0;
              if (b == KEY_RD) keys_d[0] = 1'b0;
            end
          endcase
        end else begin
          fe_d    = 1'b1;
          state_d = S_IDLE;
        end
      end else begin
        sh_d      = {dat_s2_q, sh_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      // an edge in the same cycle takes the branch above, so it always wins
      if (tmo_q == TMO_LAST) begin
        tmo_d     = '0;
        bit_cnt_d = '0;
        fe_d      = 1'b1;
        state_d   = S_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      clk_s3_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
      state_q   <= S_IDLE;
      keys_q    <= '0;
      code_q    <= '0;
      cv_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      clk_s1_q  <= ps2_clk;
      clk_s2_q  <= clk_s1_q;
      clk_s3_q  <= clk_s2_q;
      dat_s1_q  <= ps2_data;
      dat_s2_q  <= dat_s1_q;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_q     <= tmo_d;
      state_q   <= state_d;
      keys_q    <= keys_d;
      code_q    <= code_d;
      cv_q      <= cv_d;
      fe_q      <= fe_d;
    end
  end

  assign keys       = keys_q;
  assign key_code   = code_q;
  assign code_valid = cv_q;
  assign frame_err  = fe_q;

endmodule
